// File: rtl/uart_tx_sched.sv
// Frame scheduler for a byte UART: round-robin grant between two requesters,
// then SYNC, ID, payload high, payload low and an 8-bit additive checksum.
module uart_tx_sched #(
   parameter logic [7:0] SYNC = 8'hA5,
   parameter logic [7:0] ID0  = 8'h01,
   parameter logic [7:0] ID1  = 8'h02
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [15:0] pay0,
   input  logic [15:0] pay1,
   output logic [1:0]  ack,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        busy,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, GRANT, SEND, WAIT} state_t;

   state_t      state_reg;
   logic [2:0]  idx_reg;
   logic        last_grant_reg;
   logic [7:0]  id_reg;
   logic [15:0] pay_reg;

   logic        winner;
   logic [7:0]  chk;
   logic [2:0]  send_idx;
   logic [7:0]  next_byte;

   // On a tie the requester that did not win last time takes the frame.
   always_comb begin
      winner = req[1];
      if (req == 2'b11) begin
         winner = ~last_grant_reg;
      end
   end

   always_comb begin
      chk = id_reg + pay_reg[15:8] + pay_reg[7:0];
      send_idx = 3'd0;
      if (state_reg == WAIT) begin
         send_idx = idx_reg + 3'd1;
      end
      case (send_idx)
         3'd0:    next_byte = SYNC;
         3'd1:    next_byte = id_reg;
         3'd2:    next_byte = pay_reg[15:8];
         3'd3:    next_byte = pay_reg[7:0];
         default: next_byte = chk;
      endcase
   end

   // Outputs are registered, so decisions are taken on the edge entering a
   // state: ack is visible during GRANT and trmt during SEND. trmt in SEND
   // lets the UART drop its stale tx_done before WAIT starts sampling it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         idx_reg        <= 3'd0;
         last_grant_reg <= 1'b1;
         id_reg         <= 8'h00;
         pay_reg        <= 16'h0000;
         ack            <= 2'b00;
         trmt           <= 1'b0;
         tx_data        <= 8'h00;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         ack        <= 2'b00;
         trmt       <= 1'b0;
         frame_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (|req) begin
                  state_reg      <= GRANT;
                  busy           <= 1'b1;
                  ack            <= winner ? 2'b10 : 2'b01;
                  last_grant_reg <= winner;
                  id_reg         <= winner ? ID1 : ID0;
                  pay_reg        <= winner ? pay1 : pay0;
                  idx_reg        <= 3'd0;
               end
            end
            GRANT: begin
               state_reg <= SEND;
               trmt      <= 1'b1;
               tx_data   <= next_byte;
            end
            SEND: begin
               state_reg <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  if (idx_reg == 3'd4) begin
                     state_reg  <= IDLE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     idx_reg   <= idx_reg + 3'd1;
                     state_reg <= SEND;
                     trmt      <= 1'b1;
                     tx_data   <= next_byte;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: UART byte-time model, event monitor,
// and a frame-level reference model of arbitration, byte order and checksum.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [15:0] pay0 = 16'h0000;
   logic [15:0] pay1 = 16'h0000;
   logic [1:0]  ack;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        busy;
   logic        frame_done;

   int errors = 0;
   int checks = 0;
   int byte_time = 4;
   int ucnt;

   logic [7:0]  tx_q[$];
   int          trmt_cyc_q[$];
   int          ack_q[$];
   int          ack_cyc_q[$];
   int          fd_cyc_q[$];
   int          fd_cnt = 0;
   int          ovl_cnt = 0;
   int          busy_bad = 0;
   int          cyc = 0;

   logic [15:0] pq0[$];
   logic [15:0] pq1[$];
   logic [7:0]  exp_bytes[$];
   int          exp_order[$];

   uart_tx_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .pay0       (pay0),
      .pay1       (pay1),
      .ack        (ack),
      .trmt       (trmt),
      .tx_data    (tx_data),
      .tx_done    (tx_done),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // UART: tx_done drops the cycle after trmt, rises byte_time cycles later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_done <= 1'b0;
         ucnt    <= 0;
      end else if (trmt) begin
         tx_done <= 1'b0;
         ucnt    <= byte_time;
      end else if (ucnt > 0) begin
         ucnt <= ucnt - 1;
         if (ucnt == 1) tx_done <= 1'b1;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         tx_q.delete(); trmt_cyc_q.delete(); ack_q.delete();
         ack_cyc_q.delete(); fd_cyc_q.delete();
         fd_cnt = 0; ovl_cnt = 0; busy_bad = 0;
      end else begin
         if (trmt) begin tx_q.push_back(tx_data); trmt_cyc_q.push_back(cyc); end
         if (ack[0]) begin ack_q.push_back(0); ack_cyc_q.push_back(cyc); end
         if (ack[1]) begin ack_q.push_back(1); ack_cyc_q.push_back(cyc); end
         if (frame_done) begin fd_cnt++; fd_cyc_q.push_back(cyc); end
         if (int'(trmt) + int'(ack[0]) + int'(ack[1]) + int'(frame_done) > 1) ovl_cnt++;
         if ((trmt || ack != 2'b00) && !busy) busy_bad++;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 2'b00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Requesters: raise req with a payload, drop it on ack, re-raise next cycle
   // while more frames remain.
   task automatic run_frames(input int n0, input int n1, input bit rnd,
                             input logic [15:0] f0, input logic [15:0] f1);
      int p0 = n0;
      int p1 = n1;
      int guard = 0;
      pq0.delete();
      pq1.delete();
      while (fd_cnt < n0 + n1 && guard < 5000) begin
         if (ack[0]) req[0] = 1'b0;
         else if (!req[0] && p0 > 0) begin
            pay0 = rnd ? 16'($urandom) : f0;
            pq0.push_back(pay0); req[0] = 1'b1; p0--;
         end
         if (ack[1]) req[1] = 1'b0;
         else if (!req[1] && p1 > 0) begin
            pay1 = rnd ? 16'($urandom) : f1;
            pq1.push_back(pay1); req[1] = 1'b1; p1--;
         end
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 5000) begin
         errors++;
         $display("FAIL run_timeout: frames_done=%0d required=%0d", fd_cnt, n0 + n1);
      end
      repeat (4) @(negedge clk);
   endtask

   // Reference: round robin from last_grant=1, frames built from spec rules.
   task automatic model_frames(input int n0, input int n1);
      int c0 = n0;
      int c1 = n1;
      int last = 1;
      int w;
      int i0 = 0;
      int i1 = 0;
      logic [15:0] p;
      logic [7:0]  id;
      exp_order.delete();
      exp_bytes.delete();
      while (c0 > 0 || c1 > 0) begin
         if (c0 > 0 && c1 > 0) w = 1 - last;
         else w = (c0 > 0) ? 0 : 1;
         last = w;
         if (w == 0) begin p = pq0[i0]; i0++; c0--; id = 8'h01; end
         else begin p = pq1[i1]; i1++; c1--; id = 8'h02; end
         exp_order.push_back(w);
         exp_bytes.push_back(8'hA5);
         exp_bytes.push_back(id);
         exp_bytes.push_back(p[15:8]);
         exp_bytes.push_back(p[7:0]);
         exp_bytes.push_back(8'((int'(id) + int'(p[15:8]) + int'(p[7:0])) % 256));
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 2'b00;
      repeat (3) @(negedge clk);
      checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL rst_trmt: got %b expected 0", trmt); end
      checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rst_ack: got %b expected 00", ack); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (busy !== 1'b0 || tx_q.size() !== 0) begin
         errors++; $display("FAIL idle_quiet: busy=%b bytes=%0d expected 0/0", busy, tx_q.size());
      end
      $display("test_reset: done");
   endtask

   task automatic test_single_frame();
      logic [7:0] e[5] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h47};
      byte_time = 4;
      do_reset();
      run_frames(1, 0, 1'b0, 16'h1234, 16'h0000);
      checks++; if (tx_q.size() !== 5) begin errors++; $display("FAIL single_count: got %0d expected 5", tx_q.size()); end
      for (int i = 0; i < 5 && i < tx_q.size(); i++) begin
         checks++; if (tx_q[i] !== e[i]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, tx_q[i], e[i]); end
      end
      checks++; if (ack_q.size() !== 1 || fd_cnt !== 1) begin
         errors++; $display("FAIL single_pulses: acks=%0d frame_done=%0d expected 1/1", ack_q.size(), fd_cnt);
      end
      if (ack_q.size() > 0 && trmt_cyc_q.size() > 0) begin
         checks++; if (trmt_cyc_q[0] - ack_cyc_q[0] !== 1) begin
            errors++; $display("FAIL single_ack_to_trmt: got %0d expected 1", trmt_cyc_q[0] - ack_cyc_q[0]);
         end
      end
      for (int i = 1; i < trmt_cyc_q.size(); i++) begin
         checks++; if (trmt_cyc_q[i] - trmt_cyc_q[i-1] !== byte_time + 2) begin
            errors++; $display("FAIL single_gap%0d: got %0d expected %0d", i, trmt_cyc_q[i] - trmt_cyc_q[i-1], byte_time + 2);
         end
      end
      if (trmt_cyc_q.size() == 5 && fd_cyc_q.size() == 1) begin
         checks++; if (fd_cyc_q[0] - trmt_cyc_q[4] !== byte_time + 2) begin
            errors++; $display("FAIL single_done_gap: got %0d expected %0d", fd_cyc_q[0] - trmt_cyc_q[4], byte_time + 2);
         end
      end
      $display("test_single_frame: bytes=%0d", tx_q.size());
   endtask

   task automatic test_tie_after_reset();
      logic [7:0] e[10] = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'h00, 8'hA5, 8'h02, 8'hFF, 8'h01, 8'h02};
      byte_time = 3;
      do_reset();
      run_frames(1, 1, 1'b0, 16'h00FF, 16'hFF01);
      checks++; if (tx_q.size() !== 10) begin errors++; $display("FAIL tie_count: got %0d expected 10", tx_q.size()); end
      for (int i = 0; i < 10 && i < tx_q.size(); i++) begin
         checks++; if (tx_q[i] !== e[i]) begin errors++; $display("FAIL tie_byte%0d: got %h expected %h", i, tx_q[i], e[i]); end
      end
      checks++; if (ack_q.size() !== 2) begin errors++; $display("FAIL tie_acks: got %0d expected 2", ack_q.size()); end
      else begin
         checks++; if (ack_q[0] !== 0 || ack_q[1] !== 1) begin
            errors++; $display("FAIL tie_order: got %0d,%0d expected 0,1", ack_q[0], ack_q[1]);
         end
      end
      $display("test_tie_after_reset: frames=%0d", fd_cnt);
   endtask

   task automatic test_round_robin();
      byte_time = int'($urandom_range(1, 4));
      do_reset();
      run_frames(3, 3, 1'b1, 16'h0000, 16'h0000);
      model_frames(3, 3);
      checks++; if (ack_q.size() !== 6) begin errors++; $display("FAIL rr_acks: got %0d expected 6", ack_q.size()); end
      for (int i = 0; i < 6 && i < ack_q.size(); i++) begin
         checks++; if (ack_q[i] !== exp_order[i]) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, ack_q[i], exp_order[i]); end
      end
      checks++; if (tx_q.size() !== exp_bytes.size()) begin errors++; $display("FAIL rr_count: got %0d expected %0d", tx_q.size(), exp_bytes.size()); end
      for (int i = 0; i < exp_bytes.size() && i < tx_q.size(); i++) begin
         checks++; if (tx_q[i] !== exp_bytes[i]) begin errors++; $display("FAIL rr_byte%0d: got %h expected %h", i, tx_q[i], exp_bytes[i]); end
      end
      for (int f = 0; f + 1 < fd_cyc_q.size() && f + 1 < ack_cyc_q.size(); f++) begin
         checks++; if (ack_cyc_q[f+1] - fd_cyc_q[f] !== 1) begin
            errors++; $display("FAIL rr_frame_gap%0d: got %0d expected 1", f, ack_cyc_q[f+1] - fd_cyc_q[f]);
         end
      end
      checks++; if (ovl_cnt !== 0 || busy_bad !== 0) begin
         errors++; $display("FAIL rr_pulses: overlaps=%0d busy_low=%0d expected 0/0", ovl_cnt, busy_bad);
      end
      for (int f = 0; f < exp_order.size(); f++)
         $display("rr frame %0d: requester %0d chk %h", f, exp_order[f], exp_bytes[5*f+4]);
   endtask

   task automatic test_payload_latch();
      logic [7:0] e[5] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h47};
      int guard = 0;
      byte_time = 3;
      do_reset();
      pay0 = 16'h1234;
      req  = 2'b01;
      while (!ack[0] && guard < 50) begin @(negedge clk); guard++; end
      req = 2'b00;
      @(negedge clk);
      pay0 = 16'hBEEF;
      while (fd_cnt < 1 && guard < 500) begin @(negedge clk); guard++; end
      checks++; if (guard >= 500) begin errors++; $display("FAIL latch_timeout: frames_done=%0d required=1", fd_cnt); end
      checks++; if (tx_q.size() !== 5) begin errors++; $display("FAIL latch_count: got %0d expected 5", tx_q.size()); end
      for (int i = 0; i < 5 && i < tx_q.size(); i++) begin
         checks++; if (tx_q[i] !== e[i]) begin errors++; $display("FAIL latch_byte%0d: got %h expected %h", i, tx_q[i], e[i]); end
      end
      $display("test_payload_latch: bytes=%0d", tx_q.size());
   endtask

   task automatic test_checksum_wrap();
      logic [7:0] e[5] = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00};
      byte_time = 2;
      do_reset();
      run_frames(0, 1, 1'b0, 16'h0000, 16'hFFFF);
      checks++; if (tx_q.size() !== 5) begin errors++; $display("FAIL wrap_count: got %0d expected 5", tx_q.size()); end
      for (int i = 0; i < 5 && i < tx_q.size(); i++) begin
         checks++; if (tx_q[i] !== e[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, tx_q[i], e[i]); end
      end
      $display("test_checksum_wrap: chk=%h", (tx_q.size() == 5) ? tx_q[4] : 8'h00);
   endtask

   task automatic test_random_traffic();
      int n0;
      int n1;
      for (int r = 0; r < 4; r++) begin
         n0 = int'($urandom_range(1, 3));
         n1 = int'($urandom_range(0, 3));
         byte_time = int'($urandom_range(1, 6));
         do_reset();
         run_frames(n0, n1, 1'b1, 16'h0000, 16'h0000);
         model_frames(n0, n1);
         checks++; if (ack_q.size() !== exp_order.size()) begin errors++; $display("FAIL rnd%0d_acks: got %0d expected %0d", r, ack_q.size(), exp_order.size()); end
         for (int i = 0; i < exp_order.size() && i < ack_q.size(); i++) begin
            checks++; if (ack_q[i] !== exp_order[i]) begin errors++; $display("FAIL rnd%0d_grant%0d: got %0d expected %0d", r, i, ack_q[i], exp_order[i]); end
         end
         checks++; if (tx_q.size() !== exp_bytes.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", r, tx_q.size(), exp_bytes.size()); end
         for (int i = 0; i < exp_bytes.size() && i < tx_q.size(); i++) begin
            checks++; if (tx_q[i] !== exp_bytes[i]) begin errors++; $display("FAIL rnd%0d_byte%0d: got %h expected %h", r, i, tx_q[i], exp_bytes[i]); end
         end
         checks++; if (ovl_cnt !== 0 || busy_bad !== 0) begin
            errors++; $display("FAIL rnd%0d_pulses: overlaps=%0d busy_low=%0d expected 0/0", r, ovl_cnt, busy_bad);
         end
         $display("rnd round %0d: n0=%0d n1=%0d byte_time=%0d frames=%0d", r, n0, n1, byte_time, fd_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      int guard = 0;
      byte_time = 6;
      do_reset();
      pay0 = 16'($urandom);
      req  = 2'b01;
      while (tx_q.size() < 3 && guard < 200) begin
         @(negedge clk);
         if (ack[0]) req = 2'b00;
         guard++;
      end
      checks++; if (guard >= 200) begin errors++; $display("FAIL mid_timeout: bytes=%0d required=3", tx_q.size()); end
      req   = 2'b00;
      rst_n = 1'b0;
      #1;
      checks++; if (trmt !== 1'b0 || ack !== 2'b00 || frame_done !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
         errors++; $display("FAIL mid_reset_outputs: trmt=%b ack=%b fd=%b busy=%b tx_data=%h expected 0/00/0/0/00",
                            trmt, ack, frame_done, busy, tx_data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      checks++; if (tx_q.size() !== 0 || fd_cnt !== 0) begin
         errors++; $display("FAIL mid_no_resume: bytes=%0d frame_done=%0d expected 0/0", tx_q.size(), fd_cnt);
      end
      run_frames(1, 0, 1'b1, 16'h0000, 16'h0000);
      model_frames(1, 0);
      checks++; if (tx_q.size() !== 5) begin errors++; $display("FAIL mid_fresh_count: got %0d expected 5", tx_q.size()); end
      for (int i = 0; i < 5 && i < tx_q.size(); i++) begin
         checks++; if (tx_q[i] !== exp_bytes[i]) begin errors++; $display("FAIL mid_fresh_byte%0d: got %h expected %h", i, tx_q[i], exp_bytes[i]); end
      end
      $display("test_reset_mid_frame: fresh bytes=%0d", tx_q.size());
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_tie_after_reset();
      test_round_robin();
      test_payload_latch();
      test_checksum_wrap();
      test_random_traffic();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter SYNC, default 8'hA5, frame sync byte.
REQ-002 SHALL have parameter ID0, default 8'h01, frame ID byte for requester 0.
REQ-003 SHALL have parameter ID1, default 8'h02, frame ID byte for requester 1.
REQ-004 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  2  per-requester frame request, level, held until acked.
REQ-007 SHALL have port pay0  input  16  requester 0 payload, valid while req[0] high.
REQ-008 SHALL have port pay1  input  16  requester 1 payload, valid while req[1] high.
REQ-009 SHALL have port ack  output  2  one-cycle pulse when that requester's payload is latched.
REQ-010 SHALL have port trmt  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 SHALL have port tx_data  output  8  byte to the UART transmitter, valid when trmt is high.
REQ-012 SHALL have port tx_done  input  1  UART done flag: set at byte end, cleared one cycle after trmt.
REQ-013 SHALL have port busy  output  1  high from grant until frame end.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last frame byte completes.

Function
REQ-015 SHALL send each frame as 5 bytes in order: SYNC, ID, pay[15:8], pay[7:0], CHK.
REQ-016 SHALL compute CHK as (ID + pay[15:8] + pay[7:0]) mod 256, 8-bit wrap, with no carry kept.
REQ-017 SHALL implement states IDLE, GRANT, SEND and WAIT.
REQ-018 IDLE SHALL move to GRANT when any req bit is high, and SHALL otherwise stay in IDLE.
REQ-019 GRANT (1 cycle) SHALL pick the winner, latch its payload and ID into frame registers, pulse ack for the winner only, clear byte index to 0, and move to SEND.
REQ-020 Arbitration SHALL be round-robin: with a single request, that requester wins; with both requests, the requester not granted last wins; last_grant SHALL update at each grant.
REQ-021 SEND (1 cycle) SHALL assert trmt with tx_data equal to the byte selected by the index, then move to WAIT.
REQ-022 WAIT SHALL hold until tx_done is high.
REQ-023 When tx_done is high in WAIT and the index is below 4, WAIT SHALL increment the index and move to SEND.
REQ-024 When tx_done is high in WAIT and the index equals 4, WAIT SHALL pulse frame_done and move to IDLE.
REQ-025 tx_done SHALL be ignored in IDLE, GRANT and SEND; because tx_done is still high from the prior byte in the SEND cycle, it SHALL only be sampled in WAIT.
REQ-026 Byte-to-byte gap SHALL be: trmt, then UART byte time, then a 1-cycle WAIT-exit, then the next trmt.
REQ-027 Minimum frame-to-frame gap SHALL be 2 cycles (frame_done cycle in IDLE, then GRANT).
REQ-028 The frame SHALL be immune to pay or req changes after the grant; payload is latched only at GRANT.
REQ-029 A req deasserted before its grant SHALL be dropped with no ack.
REQ-030 The frame SHALL be atomic: no preemption by the other requester mid-frame.
REQ-031 trmt, ack and frame_done SHALL each be high for exactly one cycle per event and SHALL never overlap one another.
REQ-032 tx_data SHALL hold its last value outside SEND.
REQ-033 busy SHALL be 0 only in IDLE.

Reset
REQ-034 On rst_n low, state SHALL be IDLE, index 0, last_grant = 1 (so requester 0 wins the first tie), and frame registers 0.
REQ-035 On rst_n low, trmt, ack, frame_done and busy SHALL be 0 and tx_data SHALL be 8'h00.
REQ-036 A reset mid-frame SHALL abort the frame immediately; no frame_done SHALL follow, and the remaining bytes SHALL NOT be sent after release.
REQ-037 After reset release, the first trmt SHALL occur no earlier than 2 cycles after a req is seen.

Verification
REQ-038 Single frame: req=2'b01 with pay0=16'h1234 -> one ack[0] pulse, then bytes A5,01,12,34,47, exactly 5 trmt pulses, then frame_done.
REQ-039 Tie after reset: req=2'b11 held, pay0=16'h00FF, pay1=16'hFF01 -> frame 0 (A5,01,00,FF,00) then frame 1 (A5,02,FF,01,02), with ack[0] before ack[1].
REQ-040 Round-robin fairness: both requesters reasserting continuously for 6 frames -> grants alternate 0,1,0,1,0,1.
REQ-041 Payload latch: change pay0 from 16'h1234 to 16'hBEEF one cycle after ack[0] -> bytes are still 12,34 and CHK is 47.
REQ-042 Checksum wrap: pay1=16'hFFFF with ID1=02 -> CHK = (02+FF+FF) mod 256 = 8'h00.
REQ-043 Reset after the 3rd byte's trmt -> outputs at reset values, busy=0, no further trmt or frame_done pulse, and the next req starts a fresh frame at SYNC.
